// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state enum, bus widths, default timeout read data and grant encoder for mem_arbiter
package mem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = 4;
  localparam logic [MEM_DATA_W-1:0] MEM_ERR_RDATA = 32'hDEAD_BEEF;
  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: busy-cycle counter (clk, reset, start clears, done holds, expired when count reaches TIMEOUT_CYCLES)
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic done,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (start) count <= '0;
    else if (!done && !expired) count <= count + CW'(1);
  assign expired = count == CW'(TIMEOUT_CYCLES);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master picorv32 bus arbiter (m0_*/m1_* masters, s_* memory port, grant one-hot owner, timeout_err sticky; MEM_ARB_TIMEOUT_EN enables slave timeout)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [MEM_DATA_W-1:0] ERR_RDATA = MEM_ERR_RDATA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_valid,
  input  logic                  m0_instr,
  input  logic [MEM_ADDR_W-1:0] m0_addr,
  input  logic [MEM_DATA_W-1:0] m0_wdata,
  input  logic [MEM_STRB_W-1:0] m0_wstrb,
  output logic                  m0_ready,
  output logic [MEM_DATA_W-1:0] m0_rdata,
  input  logic                  m1_valid,
  input  logic                  m1_instr,
  input  logic [MEM_ADDR_W-1:0] m1_addr,
  input  logic [MEM_DATA_W-1:0] m1_wdata,
  input  logic [MEM_STRB_W-1:0] m1_wstrb,
  output logic                  m1_ready,
  output logic [MEM_DATA_W-1:0] m1_rdata,
  output logic                  s_valid,
  output logic                  s_instr,
  output logic [MEM_ADDR_W-1:0] s_addr,
  output logic [MEM_DATA_W-1:0] s_wdata,
  output logic [MEM_STRB_W-1:0] s_wstrb,
  input  logic                  s_ready,
  input  logic [MEM_DATA_W-1:0] s_rdata,
  output logic [1:0]            grant,
  output logic                  timeout_err
);
  arb_state_t state, state_nxt;
  logic gnt_idx, last, req, pick, busy, sel_valid, rdy, timeout;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign req = m0_valid | m1_valid;
  assign pick = (m0_valid & m1_valid) ? ~last : m1_valid;
  assign busy = state == ARB_BUSY;
  assign sel_valid = gnt_idx ? m1_valid : m0_valid;
  assign rdy = busy & (s_ready | timeout);
  always_comb begin
    state_nxt = state;
    if (busy) state_nxt = (rdy | ~sel_valid) ? ARB_IDLE : ARB_BUSY;
    else if (req) state_nxt = ARB_BUSY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= ARB_IDLE;
      gnt_idx <= 1'b0;
      last    <= 1'b1;
      grant   <= 2'b00;
    end else begin
      state <= state_nxt;
      if (!busy && req) begin
        gnt_idx <= pick;
        grant   <= onehot(pick);
      end else if (busy && state_nxt == ARB_IDLE) grant <= 2'b00;
      if (rdy) last <= gnt_idx;
    end
  // A timed-out write is dropped by pulling s_valid low while the master is released.
  assign s_valid  = busy & sel_valid & ~timeout;
  assign s_instr  = busy & (gnt_idx ? m1_instr : m0_instr);
  assign s_addr   = busy ? (gnt_idx ? m1_addr : m0_addr) : '0;
  assign s_wdata  = busy ? (gnt_idx ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb  = busy ? (gnt_idx ? m1_wstrb : m0_wstrb) : '0;
  assign m0_ready = rdy & ~gnt_idx;
  assign m1_ready = rdy & gnt_idx;
  assign m0_rdata = timeout ? ERR_RDATA : s_rdata;
  assign m1_rdata = timeout ? ERR_RDATA : s_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;
  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .start(~busy & req),
    .done(s_ready),
    .expired(expired)
  );
  assign timeout = busy & expired & ~s_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) timeout_err <= 1'b0;
    else if (timeout) timeout_err <= 1'b1;
`else
  assign timeout = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
